// File: rtl/driver_motor_paso.sv
// Half-step stepper driver for one tracker axis.
// It keeps the absolute position, enforces soft limits and releases the coils after a holding timeout.
module driver_motor_paso #(
    parameter int unsigned DIV_PASO    = 50000,
    parameter int unsigned T_RETENCION = 5000000,
    parameter logic [15:0] POS_MIN     = 16'd0,
    parameter logic [15:0] POS_MAX     = 16'd4095,
    parameter logic [15:0] POS_INICIAL = 16'd2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cmd,
    output logic [3:0]  bobinas,
    output logic [15:0] posicion,
    output logic        paso,
    output logic        en_limite,
    output logic        activo
);

    localparam logic [1:0] APAGADO   = 2'd0;
    localparam logic [1:0] MOVER     = 2'd1;
    localparam logic [1:0] RETENCION = 2'd2;

    localparam logic [31:0] PRESC_FIN = 32'(DIV_PASO - 1);
    localparam logic [31:0] HOLD_FIN  = 32'(T_RETENCION - 1);

    logic [1:0]  estado_q, estado_d;
    logic [2:0]  fase_q, fase_d;
    logic [15:0] pos_q, pos_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] hold_q, hold_d;
    logic [3:0]  bob_q, bob_d;
    logic        paso_q, paso_d;
    logic        lim_q, lim_d;
    logic        act_q, act_d;
    logic        dir_ok;

    function automatic logic [3:0] tabla(input logic [2:0] f);
        case (f)
            3'd0:    tabla = 4'b1000;
            3'd1:    tabla = 4'b1100;
            3'd2:    tabla = 4'b0100;
            3'd3:    tabla = 4'b0110;
            3'd4:    tabla = 4'b0010;
            3'd5:    tabla = 4'b0011;
            3'd6:    tabla = 4'b0001;
            default: tabla = 4'b1001;
        endcase
    endfunction

    always_comb begin
        estado_d = estado_q;
        fase_d   = fase_q;
        pos_d    = pos_q;
        presc_d  = presc_q;
        hold_d   = hold_q;
        paso_d   = 1'b0;
        dir_ok   = cmd[0] ? (pos_q != POS_MIN) : (pos_q != POS_MAX);
        lim_d    = (cmd == 2'b10 && pos_q == POS_MAX) ||
                   (cmd == 2'b11 && pos_q == POS_MIN);
        case (estado_q)
            APAGADO: begin
                if (cmd[1]) begin
                    estado_d = MOVER;
                    presc_d  = '0;
                end
            end
            MOVER: begin
                // Dropping the request wins over a tick landing in the same cycle.
                if (!cmd[1]) begin
                    estado_d = RETENCION;
                    presc_d  = '0;
                    hold_d   = '0;
                end else if (presc_q == PRESC_FIN) begin
                    presc_d = '0;
                    if (dir_ok) begin
                        paso_d = 1'b1;
                        if (cmd[0]) begin
                            fase_d = fase_q - 3'd1;
                            pos_d  = pos_q - 16'd1;
                        end else begin
                            fase_d = fase_q + 3'd1;
                            pos_d  = pos_q + 16'd1;
                        end
                    end
                end else begin
                    presc_d = presc_q + 32'd1;
                end
            end
            RETENCION: begin
                if (cmd[1]) begin
                    estado_d = MOVER;
                    presc_d  = '0;
                end else if (hold_q == HOLD_FIN) begin
                    estado_d = APAGADO;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            default: estado_d = APAGADO;
        endcase
        bob_d = (estado_d == APAGADO) ? 4'b0000 : tabla(fase_d);
        act_d = (estado_d == MOVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= APAGADO;
            fase_q   <= 3'd0;
            pos_q    <= POS_INICIAL;
            presc_q  <= '0;
            hold_q   <= '0;
            bob_q    <= 4'b0000;
            paso_q   <= 1'b0;
            lim_q    <= 1'b0;
            act_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            fase_q   <= fase_d;
            pos_q    <= pos_d;
            presc_q  <= presc_d;
            hold_q   <= hold_d;
            bob_q    <= bob_d;
            paso_q   <= paso_d;
            lim_q    <= lim_d;
            act_q    <= act_d;
        end
    end

    assign bobinas   = bob_q;
    assign posicion  = pos_q;
    assign paso      = paso_q;
    assign en_limite = lim_q;
    assign activo    = act_q;

endmodule
